// File: rtl/pcm_framer.sv
// pcm_framer: buffers a PCM sample stream in a circular RAM and emits overlapping
//   analysis frames (FRAME_SIZE samples, hop FRAME_MOVE) on a valid/ready stream.
// Latency: frame_valid_o rises 2 cycles after the edge that writes the FRAME_SIZE-th sample;
//   one sample per cycle while frame_ready_i=1. Backpressure: output is held stable while
//   valid & !ready. The input has no backpressure: a sample arriving when the buffer is full
//   is dropped and overflow_o is set (sticky until rst).
// Ports:
//   clk, rst (sync, active high)   | pcm_in, pcm_ready_i   : input sample + strobe
//   frame_data_o / frame_valid_o / frame_ready_i             : output stream
//   frame_idx_o (sample index in frame), frame_last_o (final sample of frame)
//   frame_count_o (completed frames, wraps), overflow_o (sticky drop flag)
// Build option: define PCM_FRAMER_ZEROPAD_EN to append FFT_SIZE-FRAME_SIZE zeros per frame.
module pcm_framer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FRAME_SIZE   = 400,
  parameter int FRAME_MOVE   = 160,
  parameter int FFT_SIZE     = 512,
  parameter int BUF_DEPTH    = 1024
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SAMPLE_WIDTH-1:0]     pcm_in,
  input  logic                        pcm_ready_i,
  output logic [SAMPLE_WIDTH-1:0]     frame_data_o,
  output logic                        frame_valid_o,
  input  logic                        frame_ready_i,
  output logic [$clog2(FFT_SIZE)-1:0] frame_idx_o,
  output logic                        frame_last_o,
  output logic [15:0]                 frame_count_o,
  output logic                        overflow_o
);

  localparam int ADDR_W = $clog2(BUF_DEPTH);
  localparam int IDX_W  = $clog2(FFT_SIZE);

`ifdef PCM_FRAMER_ZEROPAD_EN
  localparam int LAST_IDX = FFT_SIZE - 1;
  localparam bit HAS_PAD  = (FFT_SIZE > FRAME_SIZE);
`else
  localparam int LAST_IDX = FRAME_SIZE - 1;
`endif

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W:0]  FS_FILL    = (ADDR_W+1)'(FRAME_SIZE);
  localparam logic [ADDR_W:0]  FULL_FILL  = (ADDR_W+1)'(BUF_DEPTH);
  localparam logic [ADDR_W:0]  MOVE_STEP  = (ADDR_W+1)'(FRAME_MOVE);
  localparam logic [IDX_W-1:0] IDX_FS_END = IDX_W'(FRAME_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LAST_IDX);

  logic [SAMPLE_WIDTH-1:0] mem [BUF_DEPTH];

  // Pointers carry one extra bit so fill distinguishes full from empty.
  logic [ADDR_W:0]         wr_ptr;
  logic [ADDR_W:0]         start_ptr;
  logic [ADDR_W:0]         fill;
  logic [ADDR_W-1:0]       rd_ptr;
  logic [1:0]              state;
  logic [SAMPLE_WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    last_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_nxt;
  logic [15:0]             count_q;
  logic                    overflow_q;
  logic                    full;
  logic                    frame_avail;
  logic                    hs;

  assign fill        = wr_ptr - start_ptr;
  assign full        = (fill == FULL_FILL);
  assign frame_avail = (fill >= FS_FILL);
  assign hs          = valid_q & frame_ready_i;
  assign idx_nxt     = idx_q + IDX_W'(1);

  // Start region is protected by the full check: start_ptr only advances in S_DONE.
  always_ff @(posedge clk) begin
    if (pcm_ready_i && !full)
      mem[wr_ptr[ADDR_W-1:0]] <= pcm_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      start_ptr  <= '0;
      rd_ptr     <= '0;
      state      <= S_IDLE;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pcm_ready_i) begin
        if (!full) wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
        else       overflow_q <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (frame_avail) begin
            state  <= S_EMIT;
            rd_ptr <= start_ptr[ADDR_W-1:0];
            idx_q  <= '0;
          end
        end

        S_EMIT: begin
          if (!valid_q) begin
            // First read of the frame; the RAM read output lands directly in data_q.
            data_q  <= mem[rd_ptr];
            rd_ptr  <= rd_ptr + ADDR_W'(1);
            valid_q <= 1'b1;
            idx_q   <= '0;
            last_q  <= (IDX_LAST == '0);
          end else if (hs) begin
            if (idx_q == IDX_FS_END) begin
`ifdef PCM_FRAMER_ZEROPAD_EN
              if (HAS_PAD) begin
                state  <= S_PAD;
                data_q <= '0;
                idx_q  <= idx_nxt;
                last_q <= (idx_nxt == IDX_LAST);
              end else begin
                state   <= S_DONE;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
              end
`else
              state   <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
`endif
            end else begin
              data_q <= mem[rd_ptr];
              rd_ptr <= rd_ptr + ADDR_W'(1);
              idx_q  <= idx_nxt;
              last_q <= (idx_nxt == IDX_LAST);
            end
          end
        end

`ifdef PCM_FRAMER_ZEROPAD_EN
        S_PAD: begin
          if (hs) begin
            if (idx_q == IDX_LAST) begin
              state   <= S_DONE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
            end else begin
              idx_q  <= idx_nxt;
              last_q <= (idx_nxt == IDX_LAST);
            end
          end
        end
`endif

        S_DONE: begin
          start_ptr <= start_ptr + MOVE_STEP;
          count_q   <= count_q + 16'd1;
          state     <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign frame_data_o  = data_q;
  assign frame_valid_o = valid_q;
  assign frame_idx_o   = idx_q;
  assign frame_last_o  = last_q;
  assign frame_count_o = count_q;
  assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_pcm_framer.sv
// Scoreboard bench for pcm_framer: expected frame samples are queued when stimulus is
// issued; a negedge monitor pops and compares on every output handshake and checks that
// stalled outputs stay stable.
module tb_pcm_framer;

  localparam int SW   = 16;
  localparam int FS   = 400;
  localparam int FM   = 160;
  localparam int FFT  = 512;
  localparam int BD   = 1024;
  localparam int IW   = $clog2(FFT);
`ifdef PCM_FRAMER_ZEROPAD_EN
  localparam int FLEN = FFT;
`else
  localparam int FLEN = FS;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] pcm_in = '0;
  logic          pcm_ready_i = 1'b0;
  logic [SW-1:0] frame_data_o;
  logic          frame_valid_o;
  logic          frame_ready_i = 1'b0;
  logic [IW-1:0] frame_idx_o;
  logic          frame_last_o;
  logic [15:0]   frame_count_o;
  logic          overflow_o;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;  // 0: ready high, 1: random, 2: ready low

  // Expected entry packs {data, idx, last}.
  logic [SW+IW:0] exp_q[$];

  pcm_framer #(.SAMPLE_WIDTH(SW), .FRAME_SIZE(FS), .FRAME_MOVE(FM),
               .FFT_SIZE(FFT), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst), .pcm_in(pcm_in), .pcm_ready_i(pcm_ready_i),
    .frame_data_o(frame_data_o), .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i), .frame_idx_o(frame_idx_o),
    .frame_last_o(frame_last_o), .frame_count_o(frame_count_o),
    .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int start);
    for (int i = 0; i < FLEN; i++) begin
      logic [SW-1:0] d;
      d = (i < FS) ? SW'(start + i) : '0;
      exp_q.push_back({d, IW'(i), (i == FLEN - 1)});
    end
  endtask

  // Called just after a posedge; one sample per cycle, then gap idle cycles.
  task automatic feed(input int n, input int start, input int gap);
    for (int i = 0; i < n; i++) begin
      pcm_in = SW'(start + i);
      pcm_ready_i = 1'b1;
      @(posedge clk); #1;
      pcm_ready_i = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pcm_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       frame_ready_i = 1'b1;
        1:       frame_ready_i = 1'($urandom_range(0, 1));
        default: frame_ready_i = 1'b0;
      endcase
    end
  end

  // Monitor: compares every handshake against the scoreboard and checks stall stability.
  logic          prev_stall = 1'b0;
  logic [SW+IW:0] prev_out = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {frame_valid_o, frame_data_o, frame_idx_o, frame_last_o},
              {1'b1, prev_out});
      if (frame_valid_o && frame_ready_i) begin
        if (exp_q.size() == 0)
          check("unexpected_out", {frame_data_o, frame_idx_o, frame_last_o}, 32'hFFFF_FFFF);
        else
          check("frame_sample", {frame_data_o, frame_idx_o, frame_last_o}, exp_q.pop_front());
      end
      prev_stall <= frame_valid_o && !frame_ready_i;
      prev_out   <= {frame_data_o, frame_idx_o, frame_last_o};
    end
  end

  initial begin
    int vcnt;
    int n;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_valid", 32'(frame_valid_o), 32'd0);
    check("rst_data", 32'(frame_data_o), 32'd0);
    check("rst_idx", 32'(frame_idx_o), 32'd0);
    check("rst_last", 32'(frame_last_o), 32'd0);
    check("rst_count", 32'(frame_count_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);

    // Ramp, ready high: frames starting at 0, 160, 320
    rdy_mode = 0;
    push_frame(0); push_frame(160); push_frame(320);
    @(posedge clk); #1;
    feed(720, 0, 0);
    drain("ramp", 5000);
    check("ramp_count", 32'(frame_count_o), 32'd3);
    check("ramp_ovf", 32'(overflow_o), 32'd0);
    check("ramp_idle_valid", 32'(frame_valid_o), 32'd0);

    // 399 samples: no frame; the 400th gives valid exactly 2 cycles later
    do_reset();
    push_frame(0);
    @(posedge clk); #1;
    feed(399, 0, 0);
    vcnt = 0;
    repeat (20) begin @(negedge clk); if (frame_valid_o) vcnt++; end
    check("short_no_valid", 32'(vcnt), 32'd0);
    @(posedge clk); #1;
    feed(1, 399, 0);
    @(negedge clk); check("lat_cyc0", 32'(frame_valid_o), 32'd0);
    @(negedge clk); check("lat_cyc1", 32'(frame_valid_o), 32'd0);
    @(negedge clk); check("lat_cyc2", 32'(frame_valid_o), 32'd1);
    drain("lat", 2000);
    check("lat_count", 32'(frame_count_o), 32'd1);

    // Random ready: same sequence as the plain ramp
    do_reset();
    rdy_mode = 1;
    push_frame(0); push_frame(160); push_frame(320);
    @(posedge clk); #1;
    feed(720, 0, 0);
    drain("rand", 10000);
    check("rand_count", 32'(frame_count_o), 32'd3);
    rdy_mode = 0;

    // Overflow: ready low, 1030 samples, 1024..1029 dropped
    do_reset();
    rdy_mode = 2;
    push_frame(0); push_frame(160); push_frame(320); push_frame(480);
    @(posedge clk); #1;
    feed(1030, 0, 0);
    @(negedge clk);
    check("ovf_set", 32'(overflow_o), 32'd1);
    rdy_mode = 0;
    drain("ovf", 5000);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("ovf_count", 32'(frame_count_o), 32'd4);

    // Pointer wrap: 2000 samples paced slowly enough to avoid overflow
    do_reset();
    for (int k = 0; k * FM + FS <= 2000; k++) push_frame(k * FM);
    @(posedge clk); #1;
    feed(2000, 0, 3);
    drain("wrap", 5000);
    check("wrap_count", 32'(frame_count_o), 32'd11);
    check("wrap_ovf", 32'(overflow_o), 32'd0);

    // Reset in the middle of frame 1
    do_reset();
    push_frame(0); push_frame(160);
    @(posedge clk); #1;
    feed(560, 0, 0);
    n = 0;
    while (!(frame_valid_o && frame_idx_o == IW'(200) && frame_count_o == 16'd1) && n < 3000) begin
      @(negedge clk); n++;
    end
    check("midrst_reached", 32'(n < 3000), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(frame_valid_o), 32'd0);
    check("midrst_count", 32'(frame_count_o), 32'd0);
    check("midrst_ovf", 32'(overflow_o), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    push_frame(0);
    @(posedge clk); #1;
    feed(400, 1000, 0);
    // Refilled frame holds the new samples starting from buffer position 0
    exp_q.delete();
    push_frame(1000);
    drain("refill", 2000);
    check("refill_count", 32'(frame_count_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
